// File: rtl/slot_bus_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : slot_bus_pkg
// Brief    : Shared types and widths for the slot bus MMIO initiator.
// Revision : 1.0 - initial release
// ============================================================================
package slot_bus_pkg;

    localparam int REG_AW  = 5;
    localparam int DW      = 32;
    localparam int SLOT_IW = 6;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_POLL  = 2'd2
    } op_t;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_TIMEOUT = 2'd1,
        ST_BADSLOT = 2'd2
    } status_t;

    // Encoding 3 is reserved and behaves as a plain read.
    function automatic op_t decode_op(input logic [1:0] raw);
        case (raw)
            2'd0:    return OP_WRITE;
            2'd2:    return OP_POLL;
            default: return OP_READ;
        endcase
    endfunction

endpackage : slot_bus_pkg
`default_nettype wire

// File: rtl/slot_bus_master_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : slot_bus_master_if
// Brief    : Command/response handshake plus broadcast slot bus bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface slot_bus_master_if
    import slot_bus_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    parameter int TO_W      = 16
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [1:0]                cmd_op;
    logic [SLOT_IW-1:0]        cmd_slot;
    logic [REG_AW-1:0]         cmd_reg;
    logic [DW-1:0]             cmd_data;
    logic [DW-1:0]             cmd_mask;
    logic [TO_W-1:0]           cmd_timeout;

    logic                      resp_valid;
    logic                      resp_ready;
    logic [DW-1:0]             resp_data;
    logic [1:0]                resp_status;

    logic [NUM_SLOTS-1:0]      slot_cs;
    logic                      slot_read;
    logic                      slot_write;
    logic [REG_AW-1:0]         slot_addr;
    logic [DW-1:0]             slot_wr_data;
    logic [DW*NUM_SLOTS-1:0]   slot_rd_data;

    modport master (
        input  cmd_valid, cmd_op, cmd_slot, cmd_reg, cmd_data, cmd_mask, cmd_timeout,
        input  resp_ready, slot_rd_data,
        output cmd_ready, resp_valid, resp_data, resp_status,
        output slot_cs, slot_read, slot_write, slot_addr, slot_wr_data
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_slot, cmd_reg, cmd_data, cmd_mask, cmd_timeout,
        output resp_ready, slot_rd_data,
        input  cmd_ready, resp_valid, resp_data, resp_status,
        input  slot_cs, slot_read, slot_write, slot_addr, slot_wr_data
    );

endinterface : slot_bus_master_if
`default_nettype wire

// File: rtl/slot_rd_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : slot_rd_mux
// Brief    : Picks one slot's read word out of the flat read-data vector.
// Revision : 1.0 - initial release
// ============================================================================
module slot_rd_mux
    import slot_bus_pkg::*;
#(
    parameter int NUM_SLOTS = 8
) (
    input  wire logic [DW*NUM_SLOTS-1:0] i_rd_data_flat,
    input  wire logic [SLOT_IW-1:0]      i_sel,
    output      logic [DW-1:0]           o_rd_word
);

    // Out-of-range selects yield zero.
    always_comb begin
        o_rd_word = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (i_sel == SLOT_IW'(i)) begin
                o_rd_word = i_rd_data_flat[DW*i +: DW];
            end
        end
    end

endmodule : slot_rd_mux
`default_nettype wire

// File: rtl/slot_bus_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : slot_bus_master
// Brief    : Single-command MMIO initiator (write/read/poll) for the slot bus.
// Revision : 1.0 - initial release
// ============================================================================
module slot_bus_master
    import slot_bus_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    parameter int TO_W      = 16
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    slot_bus_master_if.master      bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_GAP  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [SLOT_IW:0]    c_num_slots = (SLOT_IW+1)'(NUM_SLOTS);
    localparam logic [NUM_SLOTS-1:0] c_cs_lsb   = NUM_SLOTS'(1);

    state_t               r_state;
    op_t                  r_op;
    logic [SLOT_IW-1:0]   r_slot;
    logic [DW-1:0]        r_data;
    logic [DW-1:0]        r_mask;
    logic [TO_W-1:0]      r_timeout;
    logic [TO_W-1:0]      r_attempt;

    logic [NUM_SLOTS-1:0] r_cs;
    logic                 r_read;
    logic                 r_write;
    logic [REG_AW-1:0]    r_addr;
    logic [DW-1:0]        r_wr_data;
    logic                 r_resp_valid;
    logic [DW-1:0]        r_resp_data;
    status_t              r_resp_status;

    op_t                  w_cmd_op;
    logic                 w_slot_ok;
    logic [NUM_SLOTS-1:0] w_cmd_cs;
    logic [DW-1:0]        w_rd_word;
    logic                 w_match;

    slot_rd_mux #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_rd_mux (
        .i_rd_data_flat (bus.slot_rd_data),
        .i_sel          (r_slot),
        .o_rd_word      (w_rd_word)
    );

    assign w_cmd_op  = decode_op(bus.cmd_op);
    assign w_slot_ok = ({1'b0, bus.cmd_slot} < c_num_slots);
    assign w_cmd_cs  = c_cs_lsb << bus.cmd_slot;
    assign w_match   = (((w_rd_word ^ r_data) & r_mask) == '0);

    // Strobes default low every cycle; they are only raised on entry to XFER.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_op          <= OP_WRITE;
            r_slot        <= '0;
            r_data        <= '0;
            r_mask        <= '0;
            r_timeout     <= '0;
            r_attempt     <= '0;
            r_cs          <= '0;
            r_read        <= 1'b0;
            r_write       <= 1'b0;
            r_addr        <= '0;
            r_wr_data     <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_data   <= '0;
            r_resp_status <= ST_OK;
        end else begin
            r_cs    <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_op      <= w_cmd_op;
                        r_slot    <= bus.cmd_slot;
                        r_data    <= bus.cmd_data;
                        r_mask    <= bus.cmd_mask;
                        r_timeout <= bus.cmd_timeout;
                        r_attempt <= '0;
                        r_addr    <= bus.cmd_reg;
                        r_wr_data <= bus.cmd_data;
                        if (!w_slot_ok) begin
                            r_state       <= S_RESP;
                            r_resp_valid  <= 1'b1;
                            r_resp_data   <= '0;
                            r_resp_status <= ST_BADSLOT;
                        end else begin
                            r_state <= S_XFER;
                            r_cs    <= w_cmd_cs;
                            r_write <= (w_cmd_op == OP_WRITE);
                            r_read  <= (w_cmd_op != OP_WRITE);
                        end
                    end
                end
                S_XFER: begin
                    if (r_op == OP_WRITE) begin
                        r_state       <= S_RESP;
                        r_resp_valid  <= 1'b1;
                        r_resp_data   <= '0;
                        r_resp_status <= ST_OK;
                    end else if (r_op != OP_POLL || w_match) begin
                        r_state       <= S_RESP;
                        r_resp_valid  <= 1'b1;
                        r_resp_data   <= w_rd_word;
                        r_resp_status <= ST_OK;
                    end else if (r_attempt == r_timeout) begin
                        r_state       <= S_RESP;
                        r_resp_valid  <= 1'b1;
                        r_resp_data   <= w_rd_word;
                        r_resp_status <= ST_TIMEOUT;
                    end else begin
                        r_attempt <= r_attempt + 1'b1;
                        r_state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    r_state <= S_XFER;
                    r_cs    <= c_cs_lsb << r_slot;
                    r_read  <= 1'b1;
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready    = (r_state == S_IDLE);
    assign bus.resp_valid   = r_resp_valid;
    assign bus.resp_data    = r_resp_data;
    assign bus.resp_status  = r_resp_status;
    assign bus.slot_cs      = r_cs;
    assign bus.slot_read    = r_read;
    assign bus.slot_write   = r_write;
    assign bus.slot_addr    = r_addr;
    assign bus.slot_wr_data = r_wr_data;

endmodule : slot_bus_master
`default_nettype wire

// File: tb/tb_slot_bus_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_slot_bus_master
// Brief    : Directed self-checking bench with a cycle-level transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slot_bus_master;
    import slot_bus_pkg::*;

    localparam int N  = 6;
    localparam int TW = 16;
    localparam int SCHED = 1024;

    logic clk = 1'b0;
    logic reset_n;

    slot_bus_master_if #(.NUM_SLOTS(N), .TO_W(TW)) bus ();

    slot_bus_master #(.NUM_SLOTS(N), .TO_W(TW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- slot models ----------------
    logic [31:0] slot_base [N];
    int cnt3      = 0;
    int base3     = 0;
    int match_at3 = 1000;

    // Slot 3 returns a distinct non-matching word per read until read index m.
    function automatic logic [31:0] slot3_val(input int n, input int m);
        return (n >= m) ? 32'h0000_0010 : (32'h0000_A500 + 32'(n));
    endfunction

    function automatic logic [31:0] slot_val(input int s, input int n);
        return (s == 3) ? slot3_val(n, match_at3) : slot_base[s];
    endfunction

    always_comb begin
        bus.slot_rd_data = '0;
        for (int i = 0; i < N; i++) begin
            bus.slot_rd_data[32*i +: 32] = (i == 3) ? slot3_val(cnt3 - base3, match_at3) : slot_base[i];
        end
    end

    always @(posedge clk) begin
        if (bus.slot_read && bus.slot_cs[3]) cnt3 <= cnt3 + 1;
    end

    // ---------------- transaction model ----------------
    bit          m_busy    = 1'b0;
    int          m_resp_at = 0;
    logic [31:0] m_rdata   = '0;
    logic [1:0]  m_rstat   = '0;
    logic [4:0]  m_addr    = '0;
    logic [31:0] m_wdata   = '0;
    int          exp_kind [SCHED];   // 0 none, 1 write strobe, 2 read strobe
    int          exp_slot [SCHED];

    initial begin
        for (int i = 0; i < SCHED; i++) begin
            exp_kind[i] = 0;
            exp_slot[i] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset_n) begin
                m_busy  = 1'b0;
                m_addr  = '0;
                m_wdata = '0;
                for (int i = 0; i < SCHED; i++) exp_kind[i] = 0;
            end else if (!m_busy) begin
                if (bus.cmd_valid) begin
                    int s;
                    s       = int'(bus.cmd_slot);
                    m_busy  = 1'b1;
                    m_addr  = bus.cmd_reg;
                    m_wdata = bus.cmd_data;
                    if (s >= N) begin
                        m_resp_at = cyc; m_rdata = '0; m_rstat = 2'd2;
                    end else if (bus.cmd_op == 2'd0) begin
                        exp_kind[cyc % SCHED] = 1; exp_slot[cyc % SCHED] = s;
                        m_resp_at = cyc + 1; m_rdata = '0; m_rstat = 2'd0;
                    end else if (bus.cmd_op == 2'd2) begin
                        for (int n = 0; n <= int'(bus.cmd_timeout); n++) begin
                            logic [31:0] v;
                            v = slot_val(s, n);
                            exp_kind[(cyc + 2*n) % SCHED] = 2;
                            exp_slot[(cyc + 2*n) % SCHED] = s;
                            m_resp_at = cyc + 1 + 2*n;
                            m_rdata   = v;
                            if ((v & bus.cmd_mask) == (bus.cmd_data & bus.cmd_mask)) begin
                                m_rstat = 2'd0;
                                break;
                            end
                            m_rstat = 2'd1;
                        end
                    end else begin
                        exp_kind[cyc % SCHED] = 2; exp_slot[cyc % SCHED] = s;
                        m_resp_at = cyc + 1; m_rdata = slot_val(s, 0); m_rstat = 2'd0;
                    end
                end
            end else if ((cyc - 1) >= m_resp_at && bus.resp_ready) begin
                m_busy = 1'b0;
            end
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    initial begin
        forever begin
            int          idx;
            bit          rv;
            logic [N-1:0] ecs;
            @(posedge clk);
            #1;
            idx = cyc % SCHED;
            rv  = m_busy && (cyc >= m_resp_at);
            ecs = (exp_kind[idx] != 0) ? (N'(1) << exp_slot[idx]) : '0;
            check("mdl_cmd_ready",  64'(bus.cmd_ready),    64'(!m_busy));
            check("mdl_resp_valid", 64'(bus.resp_valid),   64'(rv));
            if (rv) begin
                check("mdl_resp_data",   64'(bus.resp_data),   64'(m_rdata));
                check("mdl_resp_status", 64'(bus.resp_status), 64'(m_rstat));
            end
            check("mdl_slot_cs",    64'(bus.slot_cs),      64'(ecs));
            check("mdl_slot_write", 64'(bus.slot_write),   64'(exp_kind[idx] == 1));
            check("mdl_slot_read",  64'(bus.slot_read),    64'(exp_kind[idx] == 2));
            check("mdl_slot_addr",  64'(bus.slot_addr),    64'(m_addr));
            check("mdl_slot_wdata", 64'(bus.slot_wr_data), 64'(m_wdata));
            exp_kind[idx] = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [1:0] op, input logic [5:0] slot, input logic [4:0] rg,
                         input logic [31:0] data, input logic [31:0] mask, input logic [15:0] to,
                         output int acc);
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!bus.cmd_ready) begin
            checks++; failures++;
            $display("FAIL issue_wait: cmd_ready stuck at 0, required 1 within 50 cycles");
        end
        bus.cmd_op      = op;
        bus.cmd_slot    = slot;
        bus.cmd_reg     = rg;
        bus.cmd_data    = data;
        bus.cmd_mask    = mask;
        bus.cmd_timeout = to;
        bus.cmd_valid   = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, n, w, c0;
        logic [6:0] pat;

        for (int i = 0; i < N; i++) slot_base[i] = 32'h1000_0000 + 32'(i * 32'h111);
        slot_base[5] = 32'hDEAD_BEEF;
        reset_n         = 1'b0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = '0;
        bus.cmd_slot    = '0;
        bus.cmd_reg     = '0;
        bus.cmd_data    = '0;
        bus.cmd_mask    = '0;
        bus.cmd_timeout = '0;
        bus.resp_ready  = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready",  64'(bus.cmd_ready),    64'd1);
        check("rst_resp_valid", 64'(bus.resp_valid),   64'd0);
        check("rst_resp_data",  64'(bus.resp_data),    64'd0);
        check("rst_slot_cs",    64'(bus.slot_cs),      64'd0);
        check("rst_strobes",    64'({bus.slot_read, bus.slot_write}), 64'd0);
        check("rst_addr_wdata", 64'({bus.slot_addr, bus.slot_wr_data}), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // WRITE slot 2 reg 2 data 3
        issue(2'd0, 6'd2, 5'd2, 32'h3, 32'h0, 16'd0, acc);
        check("wr_cs",     64'(bus.slot_cs),      64'h04);
        check("wr_strobe", 64'({bus.slot_write, bus.slot_read}), 64'b10);
        check("wr_addr",   64'(bus.slot_addr),    64'd2);
        check("wr_wdata",  64'(bus.slot_wr_data), 64'd3);
        @(negedge clk);
        check("wr_cs_drop", 64'(bus.slot_cs), 64'd0);
        check("wr_resp",    64'({bus.resp_valid, bus.resp_status, bus.resp_data}), {29'd0, 1'b1, 2'd0, 32'd0});

        // READ slot 5 reg 0
        issue(2'd1, 6'd5, 5'd0, 32'h0, 32'h0, 16'd0, acc);
        check("rd_strobe", 64'({bus.slot_read, bus.slot_write, bus.slot_cs}), 64'({1'b1, 1'b0, 6'h20}));
        @(negedge clk);
        check("rd_resp_data",   64'(bus.resp_data),   64'hDEADBEEF);
        check("rd_resp_status", 64'({bus.resp_valid, bus.resp_status}), 64'b100);

        // Reserved op 3 behaves as READ
        issue(2'd3, 6'd5, 5'd9, 32'h0, 32'h0, 16'd0, acc);
        check("op3_strobe", 64'({bus.slot_read, bus.slot_write}), 64'b10);
        @(negedge clk);
        check("op3_resp_data", 64'(bus.resp_data), 64'hDEADBEEF);

        // POLL slot 3 matching on its 4th read
        base3 = cnt3; match_at3 = 3;
        issue(2'd2, 6'd3, 5'd7, 32'h10, 32'hFF, 16'd10, acc);
        pat = '0;
        for (int i = 0; i < 7; i++) begin
            pat[i] = bus.slot_read;
            @(negedge clk);
        end
        check("poll_read_pattern", 64'(pat), 64'b1010101);
        check("poll_resp", 64'({bus.resp_valid, bus.resp_status, bus.resp_data}), {29'd0, 1'b1, 2'd0, 32'h10});

        // POLL timeout 2, never matching
        base3 = cnt3; match_at3 = 1000;
        issue(2'd2, 6'd3, 5'd1, 32'h10, 32'hFF, 16'd2, acc);
        n = 0; w = 0;
        while (!bus.resp_valid && w < 40) begin
            if (bus.slot_read) n++;
            @(negedge clk);
            w++;
        end
        check("to_read_count", 64'(n), 64'd3);
        check("to_resp", 64'({bus.resp_valid, bus.resp_status, bus.resp_data}), {29'd0, 1'b1, 2'd1, 32'hA502});

        // BADSLOT: slot 7 and the first out-of-range index 6
        issue(2'd1, 6'd7, 5'd4, 32'h0, 32'h0, 16'd0, acc);
        check("bad7_resp",   64'({bus.resp_valid, bus.resp_status, bus.resp_data}), {29'd0, 1'b1, 2'd2, 32'd0});
        check("bad7_nostrb", 64'({bus.slot_read, bus.slot_write, bus.slot_cs}), 64'd0);
        issue(2'd0, 6'd6, 5'd4, 32'h77, 32'h0, 16'd0, acc);
        check("bad6_resp",   64'({bus.resp_valid, bus.resp_status}), 64'b110);

        // Back-to-back throughput
        issue(2'd0, 6'd1, 5'd3, 32'h55, 32'h0, 16'd0, acc);
        issue(2'd0, 6'd4, 5'd5, 32'h66, 32'h0, 16'd0, acc2);
        check("throughput_gap", 64'(acc2 - acc), 64'd3);
        repeat (3) @(negedge clk);

        // Backpressure
        bus.resp_ready = 1'b0;
        issue(2'd1, 6'd5, 5'd1, 32'h0, 32'h0, 16'd0, acc);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", 64'({bus.resp_valid, bus.cmd_ready, bus.slot_read, bus.slot_write, bus.resp_data}),
                  {28'd0, 4'b1000, 32'hDEADBEEF});
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 64'({bus.resp_valid, bus.cmd_ready}), 64'b01);

        // Reset in the middle of a POLL
        base3 = cnt3; match_at3 = 1000;
        issue(2'd2, 6'd3, 5'd2, 32'h10, 32'hFF, 16'd10, acc);
        @(negedge clk);
        @(negedge clk);
        check("mid_poll_read", 64'(bus.slot_read), 64'd1);
        reset_n = 1'b0;
        #1;
        check("async_rst_outs", 64'({bus.slot_read, bus.slot_write, bus.slot_cs, bus.resp_valid}), 64'd0);
        check("async_rst_ready", 64'(bus.cmd_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        c0 = cnt3;
        repeat (20) @(negedge clk);
        check("post_rst_no_reads", 64'(cnt3 - c0), 64'd0);
        check("post_rst_ready",    64'(bus.cmd_ready), 64'd1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_slot_bus_master
`default_nettype wire

// File: doc/slot_bus_master.md
# slot_bus_master

MMIO initiator for the slot bus: accepts single commands on a valid/ready port and drives one-cycle `cs`/`read`/`write` strobes to one of `NUM_SLOTS` slot cores. Supports read, write and a bounded poll-until-match operation. Returns read data and a completion status on a valid/ready response port. Sits between a processor-side command source (or a test sequencer) and the broadcast slot bus that feeds peripheral cores such as the timer.

## Interface
- `NUM_SLOTS`, 8: number of attached slots (1..64).
- `TO_W`, 16: width of the poll timeout counter.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_op` in 2: 0=WRITE, 1=READ, 2=POLL; 3 is reserved and treated as READ.
- `cmd_slot` in 6: target slot index.
- `cmd_reg` in 5: slot register address.
- `cmd_data` in 32: write data for WRITE; match value for POLL.
- `cmd_mask` in 32: POLL compare mask.
- `cmd_timeout` in TO_W: POLL retry limit.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: response consumed.
- `resp_data` out 32: read data; 0 for WRITE and BADSLOT.
- `resp_status` out 2: 0=OK, 1=TIMEOUT, 2=BADSLOT.
- `slot_cs` out NUM_SLOTS: one-hot chip select.
- `slot_read`, `slot_write` out 1: strobes.
- `slot_addr` out 5: register address.
- `slot_wr_data` out 32: write data.
- `slot_rd_data` in 32*NUM_SLOTS: flat vector; slot i occupies bits [32i+31:32i]. Slot read data is combinational from the address.

## Operation
- FSM states:
  - **IDLE**: `cmd_ready`=1. On handshake, latch op, slot, reg, data, mask and timeout. Clear the attempt counter.
    - If `cmd_slot` ≥ NUM_SLOTS, go to RESP with BADSLOT.
    - Otherwise, go to XFER.
  - **XFER**: exactly one cycle. `slot_cs[slot]`=1, `slot_addr`=reg, plus `slot_write`=1 (WRITE) or `slot_read`=1 (READ/POLL). `slot_rd_data` of the selected slot is sampled at the end of the cycle.
    - WRITE or READ: go to RESP with OK.
    - POLL: match when (rd & mask) == (data & mask).
      - On match, go to RESP with OK.
      - Else, if attempt count == timeout, go to RESP with TIMEOUT; data is the last read value.
      - Else, increment the counter and go to GAP.
  - **GAP**: one cycle, all strobes low, then back to XFER.
  - **RESP**: `resp_valid`=1 and `resp_data`/`resp_status` held stable. On `resp_ready`, go to IDLE.
- POLL issues at most timeout+1 reads. Timeout 0 gives a single read.
- `slot_addr` and `slot_wr_data` hold their last latched values outside XFER. `slot_wr_data` is driven from the latched `cmd_data` for all ops.
- Strobes are never asserted outside XFER and never to more than one slot.
- Reset mid-operation: strobes, `resp_valid` and `slot_cs` drop immediately (asynchronous). The in-flight command is discarded and the FSM returns to IDLE.

## Timing
- Reset values:
  - `cmd_ready`=1 (IDLE).
  - `resp_valid`, `resp_data`, `resp_status`, `slot_cs`, `slot_read`, `slot_write`, `slot_addr`, `slot_wr_data` = 0.
- Command accepted at edge k:
  - Strobe is high during cycle k+1.
  - `resp_valid` rises at edge k+2.
- POLL read n (0-based) occurs in cycle k+1+2n. A match on read n gives `resp_valid` at k+2+2n.
- BADSLOT: `resp_valid` at edge k+1, with no strobe.
- Throughput is one command per 3 cycles when `resp_ready` is held high. `cmd_ready` rises the cycle after the response handshake.
- All slot-bus outputs and response outputs are registered. `cmd_ready` is decoded from state.

## Structure
- `slot_bus_pkg`: `op_t` enum (WRITE/READ/POLL), `status_t` enum (OK/TIMEOUT/BADSLOT), `REG_AW`=5, `DW`=32.
- Sub-module `slot_rd_mux`: selects one 32-bit word from the flat `slot_rd_data` vector by slot index. This is combinational and parameterised by NUM_SLOTS.
- Everything else stays in one FSM module.

## Test plan
- WRITE slot 2, reg 2, data 0x3, accepted at k:
  - `slot_cs`=0x04, `slot_write`=1, `slot_addr`=2, `slot_wr_data`=3 for cycle k+1 only.
  - Response at k+2: OK, data 0.
- READ slot 5, reg 0, with slot 5 driving 0xDEADBEEF:
  - `slot_read` pulse at k+1.
  - `resp_data`=0xDEADBEEF, OK at k+2.
- POLL slot 3, mask 0xFF, data 0x10, timeout 10; slot 3 returns 0x10 from its 4th read:
  - Reads at k+1, k+3, k+5, k+7.
  - Response at k+8: OK, data 0x10.
- POLL with timeout 2, never matching:
  - Exactly 3 read strobes.
  - Status TIMEOUT with the last read data.
- NUM_SLOTS=6, `cmd_slot`=7:
  - No strobe.
  - Response at k+1: BADSLOT, data 0.
- Backpressure and reset:
  - `resp_ready` low for 5 cycles: response stable, `cmd_ready`=0, no strobes.
  - `reset_n` pulsed low mid-POLL: all outputs 0 immediately, `cmd_ready`=1 after release, no further strobes.
